wave_select_ctrl: RTL and testbench
===================================

WAVE_SELECT_CTRL -- requirements
Module: wave_select_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the duty-value bit-width shared with all waveform generators.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16, the blanking length in clocks between generator switches (legal range 1..65535).
REQ-003 The block SHALL have port clk  input  1  system clock; the design has one clock, and reset is synchronous and active-high.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port run_en  input  1  level; high runs the selected generator, low stops all.
REQ-006 The block SHALL have port mode_req_valid  input  1  mode-change request valid.
REQ-007 The block SHALL have port mode_req  input  2  requested wave_mode_t.
REQ-008 The block SHALL have port mode_req_ready  output  1  request can be accepted this cycle.
REQ-009 The block SHALL have port gen_pwm  input  4  pwm_out of generators 0..3.
REQ-010 The block SHALL have port gen_duty  input  4xWIDTH  duty outputs of generators 0..3.
REQ-011 The block SHALL have port gen_enable  output  4  one-hot or zero enable to generators.
REQ-012 The block SHALL have port pwm_out  output  1  selected PWM.
REQ-013 The block SHALL have port duty_out  output  WIDTH  selected duty value.
REQ-014 The block SHALL have port active_mode  output  2  currently committed mode.
REQ-015 The block SHALL have port busy  output  1  high while in state BLANK.

Function
REQ-016 The FSM SHALL have exactly three states: OFF, RUN and BLANK.
REQ-017 A handshake SHALL occur on a rising clk edge with mode_req_valid and mode_req_ready both high; mode_req_ready SHALL be 1 in OFF and RUN and 0 in BLANK.
REQ-018 In OFF, an accepted request SHALL set active_mode to mode_req on the next cycle; gen_enable, pwm_out and duty_out SHALL be 0.
REQ-019 From OFF with run_en=1 sampled, the FSM SHALL enter RUN next cycle with gen_enable = onehot(active_mode).
REQ-020 In RUN, pwm_out and duty_out SHALL be registered copies of gen_pwm[active_mode] and gen_duty[active_mode], one-cycle latency.
REQ-021 In RUN, an accepted request equal to active_mode SHALL have no effect.
REQ-022 In RUN, an accepted request differing from active_mode at edge T SHALL latch pending_mode, enter BLANK, and load the blank timer.
REQ-023 In BLANK, gen_enable, pwm_out and duty_out SHALL be 0 for cycles T+1..T+SETTLE_CYCLES.
REQ-024 At cycle T+SETTLE_CYCLES+1 the FSM SHALL be in RUN with active_mode = pending_mode and gen_enable = onehot(pending_mode).
REQ-025 run_en=0 sampled in RUN or BLANK SHALL force OFF next cycle with all outputs 0.
REQ-026 run_en=0 sampled in BLANK SHALL commit pending_mode to active_mode, so the request is not lost.
REQ-027 When run_en falls on the same edge as an accepted request, run_en SHALL take priority, the FSM SHALL go to OFF, and the request SHALL be treated as an OFF-state request (active_mode updated).
REQ-028 gen_enable SHALL never have more than one bit set in any cycle.
REQ-029 The blank timer SHALL be ceil(log2(SETTLE_CYCLES+1)) bits wide and SHALL not wrap.

Reset
REQ-030 Reset SHALL put the FSM in OFF and set active_mode=WAVE_SAWTOOTH, pending_mode=0, gen_enable=0, pwm_out=0, duty_out=0, busy=0, mode_req_ready=1.
REQ-031 Reset asserted mid-BLANK SHALL discard pending_mode and SHALL take priority over all other inputs.

Structure
REQ-032 The package wave_pkg SHALL hold wave_mode_t (WAVE_SAWTOOTH=0, WAVE_TRIANGLE=1, WAVE_SQUARE=2, WAVE_SINE=3), NUM_WAVES=4 and the FSM state enum.
REQ-033 The blanking counter SHALL be a sub-module wave_blank_timer (load, count-down, done pulse), instantiated once.

Verification
REQ-034 The bench SHALL check: reset, then run_en=1 -> gen_enable=4'b0001 two cycles after reset release, and pwm_out follows gen_pwm[0] one cycle late.
REQ-035 The bench SHALL check: in RUN, a request for mode 2 -> gen_enable=0 and busy=1 for exactly 16 cycles, then gen_enable=4'b0100 and active_mode=2.
REQ-036 The bench SHALL check: mode_req_valid held high during BLANK -> no handshake while ready=0, and the request is accepted on the first RUN cycle.
REQ-037 The bench SHALL check: run_en dropped at BLANK cycle 5 -> OFF next cycle with all outputs 0 and active_mode=pending; run_en=1 -> RUN with the new mode.
REQ-038 The bench SHALL check: reset at BLANK cycle 3 -> OFF with active_mode=0; SETTLE_CYCLES=1 build -> exactly one blank cycle.
REQ-039 The bench SHALL check with a continuous assertion: $onehot0(gen_enable) every cycle, and a same-mode request in RUN causes no output change.

Source files
------------

// File: rtl/wave_select_ctrl_pkg.sv
// wave_pkg: shared types for the waveform selector.
//   wave_mode_t  - generator index (sawtooth, triangle, square, sine)
//   NUM_WAVES    - number of attached generators
//   wave_state_t - selector FSM state encoding
//   mode_onehot  - generator index to enable vector
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SAWTOOTH = 2'd0,
    WAVE_TRIANGLE = 2'd1,
    WAVE_SQUARE   = 2'd2,
    WAVE_SINE     = 2'd3
  } wave_mode_t;

  localparam int NUM_WAVES = 4;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLANK = 2'd2
  } wave_state_t;

  function automatic logic [NUM_WAVES-1:0] mode_onehot(input wave_mode_t m);
    logic [NUM_WAVES-1:0] r;
    r    = '0;
    r[m] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wave_blank_timer.sv
// wave_blank_timer: down-counter that times the blanking gap between
// generator switches.
//   clk, reset - system clock, synchronous active-high reset
//   load       - reload the counter with LOAD_VAL
//   done       - one-cycle pulse on the last blanking cycle
module wave_blank_timer #(
  parameter int LOAD_VAL = 16,
  localparam int CW      = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LOAD_VAL);
    end else if (count != '0) begin
      // Stops at zero instead of wrapping.
      count <= count - CW'(1);
    end
  end

  // Count 1 marks the final blank cycle; the counter is at zero the cycle
  // after, so done is a single-cycle pulse.
  assign done = (count == CW'(1));

endmodule

// File: rtl/wave_select_ctrl.sv
// wave_select_ctrl: selects one of four waveform generators, enabling it and
// muxing its PWM and duty outputs, with a blanking gap on every mode switch.
//   clk, reset       - system clock, synchronous active-high reset
//   run_en           - level; high runs the selected generator
//   mode_req_valid   - mode-change request valid
//   mode_req         - requested wave_mode_t
//   mode_req_ready   - request can be accepted this cycle
//   gen_pwm/gen_duty - outputs of generators 0..3
//   gen_enable       - one-hot (or zero) generator enables
//   pwm_out/duty_out - registered selected generator outputs
//   active_mode      - currently committed mode
//   busy             - high while blanking
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_OFF   | all generators off; requests update active_mode directly
// ST_RUN   | active generator enabled, outputs follow it one cycle late
// ST_BLANK | switching; all outputs forced low until the timer expires
module wave_select_ctrl
  import wave_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run_en,
  input  logic                            mode_req_valid,
  input  logic [1:0]                      mode_req,
  output logic                            mode_req_ready,
  input  logic [NUM_WAVES-1:0]            gen_pwm,
  input  logic [NUM_WAVES-1:0][WIDTH-1:0] gen_duty,
  output logic [NUM_WAVES-1:0]            gen_enable,
  output logic                            pwm_out,
  output logic [WIDTH-1:0]                duty_out,
  output logic [1:0]                      active_mode,
  output logic                            busy
);

  wave_state_t state;
  wave_mode_t  active_q;
  wave_mode_t  pending_q;
  wave_mode_t  req_mode;
  logic        accept;
  logic        start_blank;
  logic        blank_done;

  assign req_mode    = wave_mode_t'(mode_req);
  assign accept      = mode_req_valid && mode_req_ready;
  assign start_blank = (state == ST_RUN) && run_en && accept && (req_mode != active_q);
  assign active_mode = active_q;

  wave_blank_timer #(
    .LOAD_VAL (SETTLE_CYCLES)
  ) u_blank_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start_blank),
    .done  (blank_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_OFF;
      active_q       <= WAVE_SAWTOOTH;
      pending_q      <= WAVE_SAWTOOTH;
      gen_enable     <= '0;
      pwm_out        <= 1'b0;
      duty_out       <= '0;
      busy           <= 1'b0;
      mode_req_ready <= 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (accept) active_q <= req_mode;
          if (run_en) begin
            state      <= ST_RUN;
            // A request taken on the same edge is already the mode to run.
            gen_enable <= mode_onehot(accept ? req_mode : active_q);
          end else begin
            gen_enable <= '0;
          end
        end

        ST_RUN: begin
          if (!run_en) begin
            // run_en wins over a simultaneous request, which is then
            // handled as if the block were already off.
            state      <= ST_OFF;
            gen_enable <= '0;
            pwm_out    <= 1'b0;
            duty_out   <= '0;
            if (accept) active_q <= req_mode;
          end else if (start_blank) begin
            state          <= ST_BLANK;
            pending_q      <= req_mode;
            gen_enable     <= '0;
            pwm_out        <= 1'b0;
            duty_out       <= '0;
            busy           <= 1'b1;
            mode_req_ready <= 1'b0;
          end else begin
            pwm_out  <= gen_pwm[active_q];
            duty_out <= gen_duty[active_q];
          end
        end

        ST_BLANK: begin
          if (!run_en) begin
            // Commit the pending mode so the request survives a stop.
            state          <= ST_OFF;
            active_q       <= pending_q;
            busy           <= 1'b0;
            mode_req_ready <= 1'b1;
          end else if (blank_done) begin
            state          <= ST_RUN;
            active_q       <= pending_q;
            gen_enable     <= mode_onehot(pending_q);
            busy           <= 1'b0;
            mode_req_ready <= 1'b1;
          end
        end

        default: begin
          state          <= ST_OFF;
          gen_enable     <= '0;
          pwm_out        <= 1'b0;
          duty_out       <= '0;
          busy           <= 1'b0;
          mode_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_select_ctrl.sv
// tb_wave_select_ctrl: scenario-based bench for wave_select_ctrl, with a
// second instance built with a one-cycle blanking gap.
module tb_wave_select_ctrl;
  import wave_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   run_en, mode_req_valid, mode_req_ready;
  logic [1:0]             mode_req, active_mode;
  logic [3:0]             gen_pwm, gen_enable;
  logic [3:0][WIDTH-1:0]  gen_duty;
  logic                   pwm_out, busy;
  logic [WIDTH-1:0]       duty_out;

  logic                   run_en_s1, valid_s1, ready_s1, pwm_s1, busy_s1;
  logic [1:0]             req_s1, active_s1;
  logic [3:0]             enable_s1;
  logic [WIDTH-1:0]       duty_s1;

  int checks = 0;
  int errors = 0;

  wave_select_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .mode_req_valid(mode_req_valid), .mode_req(mode_req), .mode_req_ready(mode_req_ready),
    .gen_pwm(gen_pwm), .gen_duty(gen_duty), .gen_enable(gen_enable),
    .pwm_out(pwm_out), .duty_out(duty_out), .active_mode(active_mode), .busy(busy)
  );

  wave_select_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset), .run_en(run_en_s1),
    .mode_req_valid(valid_s1), .mode_req(req_s1), .mode_req_ready(ready_s1),
    .gen_pwm(gen_pwm), .gen_duty(gen_duty), .gen_enable(enable_s1),
    .pwm_out(pwm_s1), .duty_out(duty_s1), .active_mode(active_s1), .busy(busy_s1)
  );

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gen_enable))
    else $error("FAIL onehot0 gen_enable=%b", gen_enable);
  a_onehot_s1: assert property (@(posedge clk) disable iff (reset) $onehot0(enable_s1))
    else $error("FAIL onehot0_s1 gen_enable=%b", enable_s1);

  // Status snapshot: {gen_enable, active_mode, busy, mode_req_ready}
  function automatic logic [7:0] st();
    return {gen_enable, active_mode, busy, mode_req_ready};
  endfunction
  function automatic logic [7:0] st1();
    return {enable_s1, active_s1, busy_s1, ready_s1};
  endfunction
  function automatic logic [7:0] ex(input logic [3:0] en, input logic [1:0] m,
                                    input logic b, input logic r);
    return {en, m, b, r};
  endfunction

  task automatic test_reset();
    reset = 1'b1; run_en = 1'b0; mode_req_valid = 1'b0; mode_req = 2'd0;
    gen_pwm = '0; gen_duty = '0;
    run_en_s1 = 1'b0; valid_s1 = 1'b0; req_s1 = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({st(), pwm_out, duty_out} !== {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {st(), pwm_out, duty_out},
               {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00});
    end
    checks++;
    if (st1() !== ex(4'b0000, 2'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_state_s1 got=%b exp=%b", st1(), ex(4'b0000, 2'd0, 1'b0, 1'b1));
    end
  endtask

  // Scoreboard: each driven generator pattern pushes the expected muxed
  // output; it is popped and compared on the following cycle.
  task automatic test_datapath(input int n, input logic [1:0] m);
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] e;
    for (int i = 0; i <= n; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pwm_out, duty_out} !== e) begin
          errors++;
          $display("FAIL datapath mode=%0d got=%h exp=%h", m, {pwm_out, duty_out}, e);
        end
      end
      if (i < n) begin
        gen_pwm = 4'($urandom);
        for (int w = 0; w < 4; w++) gen_duty[w] = WIDTH'($urandom);
        exp_q.push_back({gen_pwm[m], gen_duty[m]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_run_follow();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (st() !== ex(4'b0000, 2'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL off_after_reset got=%b exp=%b", st(), ex(4'b0000, 2'd0, 1'b0, 1'b1));
    end
    run_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({st(), pwm_out, duty_out} !== {ex(4'b0001, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL run_start got=%b exp=%b", {st(), pwm_out, duty_out},
               {ex(4'b0001, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00});
    end
    test_datapath(8, 2'd0);
  endtask

  task automatic test_switch();
    gen_pwm = 4'hF;
    for (int w = 0; w < 4; w++) gen_duty[w] = 8'hFF;
    mode_req_valid = 1'b1; mode_req = 2'd2;
    @(negedge clk);
    mode_req_valid = 1'b0;
    for (int k = 1; k <= SETTLE; k++) begin
      checks++;
      if ({st(), pwm_out, duty_out} !== {ex(4'b0000, 2'd0, 1'b1, 1'b0), 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL switch_blank cycle=%0d got=%b exp=%b", k, {st(), pwm_out, duty_out},
                 {ex(4'b0000, 2'd0, 1'b1, 1'b0), 1'b0, 8'h00});
      end
      @(negedge clk);
    end
    checks++;
    if (st() !== ex(4'b0100, 2'd2, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL switch_done got=%b exp=%b", st(), ex(4'b0100, 2'd2, 1'b0, 1'b1));
    end
    test_datapath(6, 2'd2);
  endtask

  task automatic test_hold_valid();
    mode_req_valid = 1'b1; mode_req = 2'd3;
    @(negedge clk);
    mode_req = 2'd1;
    for (int k = 1; k <= SETTLE; k++) begin
      checks++;
      if (st() !== ex(4'b0000, 2'd2, 1'b1, 1'b0)) begin
        errors++;
        $display("FAIL hold_blank cycle=%0d got=%b exp=%b", k, st(), ex(4'b0000, 2'd2, 1'b1, 1'b0));
      end
      @(negedge clk);
    end
    checks++;
    if (st() !== ex(4'b1000, 2'd3, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL hold_first_run got=%b exp=%b", st(), ex(4'b1000, 2'd3, 1'b0, 1'b1));
    end
    @(negedge clk);
    mode_req_valid = 1'b0;
    checks++;
    if (st() !== ex(4'b0000, 2'd3, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL hold_accept got=%b exp=%b", st(), ex(4'b0000, 2'd3, 1'b1, 1'b0));
    end
    repeat (SETTLE) @(negedge clk);
    checks++;
    if (st() !== ex(4'b0010, 2'd1, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL hold_done got=%b exp=%b", st(), ex(4'b0010, 2'd1, 1'b0, 1'b1));
    end
  endtask

  task automatic test_run_drop();
    gen_pwm = 4'hF;
    for (int w = 0; w < 4; w++) gen_duty[w] = 8'hFF;
    mode_req_valid = 1'b1; mode_req = 2'd2;
    @(negedge clk);
    mode_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (st() !== ex(4'b0000, 2'd1, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL drop_blank5 got=%b exp=%b", st(), ex(4'b0000, 2'd1, 1'b1, 1'b0));
    end
    run_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({st(), pwm_out, duty_out} !== {ex(4'b0000, 2'd2, 1'b0, 1'b1), 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL drop_off cycle=%0d got=%b exp=%b", k, {st(), pwm_out, duty_out},
                 {ex(4'b0000, 2'd2, 1'b0, 1'b1), 1'b0, 8'h00});
      end
    end
    run_en = 1'b1;
    @(negedge clk);
    checks++;
    if (st() !== ex(4'b0100, 2'd2, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL drop_rerun got=%b exp=%b", st(), ex(4'b0100, 2'd2, 1'b0, 1'b1));
    end
    // run_en falling together with a request: stop, and take the request.
    run_en = 1'b0; mode_req_valid = 1'b1; mode_req = 2'd0;
    @(negedge clk);
    mode_req_valid = 1'b0;
    checks++;
    if ({st(), pwm_out, duty_out} !== {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL drop_with_req got=%b exp=%b", {st(), pwm_out, duty_out},
               {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00});
    end
  endtask

  task automatic test_reset_blank();
    run_en = 1'b1;
    @(negedge clk);
    mode_req_valid = 1'b1; mode_req = 2'd3;
    @(negedge clk);
    mode_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (st() !== ex(4'b0000, 2'd0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL rstblank_blank3 got=%b exp=%b", st(), ex(4'b0000, 2'd0, 1'b1, 1'b0));
    end
    reset = 1'b1; mode_req_valid = 1'b1; mode_req = 2'd2;
    @(negedge clk);
    checks++;
    if ({st(), pwm_out, duty_out} !== {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstblank_off got=%b exp=%b", {st(), pwm_out, duty_out},
               {ex(4'b0000, 2'd0, 1'b0, 1'b1), 1'b0, 8'h00});
    end
    reset = 1'b0; run_en = 1'b0; mode_req_valid = 1'b0;
    @(negedge clk);
    run_en = 1'b1;
    @(negedge clk);
    checks++;
    if (st() !== ex(4'b0001, 2'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL rstblank_pending_dropped got=%b exp=%b", st(), ex(4'b0001, 2'd0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_same_mode();
    gen_pwm = 4'b0101;
    gen_duty[0] = 8'h5A; gen_duty[1] = 8'h11; gen_duty[2] = 8'h22; gen_duty[3] = 8'h33;
    @(negedge clk);
    mode_req_valid = 1'b1; mode_req = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({st(), pwm_out, duty_out} !== {ex(4'b0001, 2'd0, 1'b0, 1'b1), 1'b1, 8'h5A}) begin
        errors++;
        $display("FAIL same_mode cycle=%0d got=%b exp=%b", k, {st(), pwm_out, duty_out},
                 {ex(4'b0001, 2'd0, 1'b0, 1'b1), 1'b1, 8'h5A});
      end
    end
    mode_req_valid = 1'b0;
  endtask

  task automatic test_settle1();
    run_en_s1 = 1'b1;
    @(negedge clk);
    checks++;
    if (st1() !== ex(4'b0001, 2'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL s1_run got=%b exp=%b", st1(), ex(4'b0001, 2'd0, 1'b0, 1'b1));
    end
    valid_s1 = 1'b1; req_s1 = 2'd1;
    @(negedge clk);
    valid_s1 = 1'b0;
    checks++;
    if (st1() !== ex(4'b0000, 2'd0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL s1_blank got=%b exp=%b", st1(), ex(4'b0000, 2'd0, 1'b1, 1'b0));
    end
    @(negedge clk);
    checks++;
    if (st1() !== ex(4'b0010, 2'd1, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL s1_done got=%b exp=%b", st1(), ex(4'b0010, 2'd1, 1'b0, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_run_follow();
    test_switch();
    test_hold_valid();
    test_run_drop();
    test_reset_blank();
    test_same_mode();
    test_settle1();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
